vram_port_arbiter: RTL and testbench

Shares one synchronous-read VRAM port between the BGW renderer, which has strict priority and is never stalled, and a CPU-side request/done handshake that executes single-word reads or writes in cycles the renderer leaves idle. Sits between the GPU render pipeline, the memory-mapped VRAM bus interface and one VRAM block (VRAM32, VRAM8 or VRAMSPR, set by parameters). Tracks the worst-case CPU wait for firmware tuning.

---
 rtl/vram_port_arbiter_if.sv | 40 ++++
 rtl/vram_port_arbiter.sv | 86 ++++++++
 tb/tb_vram_port_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_port_arbiter_if.sv
// Bundle of renderer, CPU-handshake, VRAM and statistics signals around the
// VRAM port arbiter. "slave" is the arbiter's view, "master" the surroundings.
interface vram_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              gpu_req;
    logic [ADDR_W-1:0] gpu_addr;
    logic [DATA_W-1:0] gpu_q;

    logic              cpu_start;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic [DATA_W-1:0] cpu_q;
    logic              cpu_busy;
    logic              cpu_done;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_d;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;

    logic              stat_clear;
    logic [15:0]       stat_wait_max;

    modport slave (
        input  gpu_req, gpu_addr, cpu_start, cpu_we, cpu_addr, cpu_data,
               ram_q, stat_clear,
        output gpu_q, cpu_q, cpu_busy, cpu_done, ram_addr, ram_d, ram_we,
               stat_wait_max
    );

    modport master (
        output gpu_req, gpu_addr, cpu_start, cpu_we, cpu_addr, cpu_data,
               ram_q, stat_clear,
        input  gpu_q, cpu_q, cpu_busy, cpu_done, ram_addr, ram_d, ram_we,
               stat_wait_max
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// Single VRAM port shared between the renderer (strict priority, never
// stalled) and a CPU request/done handshake that uses renderer-idle cycles.
// Also records the longest number of cycles a CPU access waited for the port.
module vram_port_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input logic                clk,
    input logic                reset_n,
    vram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PEND, RDWAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] dat_q;
    logic              we_q;
    logic [15:0]       wait_q;
    logic [15:0]       stat_q;
    logic [DATA_W-1:0] cpu_q_q;
    logic              issue;

    // The CPU owns the port only in a PEND cycle the renderer leaves idle.
    assign issue = (state_q == PEND) && !bus.gpu_req;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; cpu_start outside IDLE is deliberately ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.cpu_start) state_d = PEND;
            PEND:    if (!bus.gpu_req)  state_d = we_q ? DONE : RDWAIT;
            RDWAIT:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Port mux and handshake outputs, all combinational from state and inputs.
    always_comb begin
        bus.ram_addr      = issue ? a_q : bus.gpu_addr;
        bus.ram_we        = issue ? we_q : 1'b0;
        bus.ram_d         = dat_q;
        bus.gpu_q         = bus.ram_q;
        bus.cpu_q         = cpu_q_q;
        bus.cpu_busy      = (state_q == PEND) || (state_q == RDWAIT);
        bus.cpu_done      = (state_q == DONE);
        bus.stat_wait_max = stat_q;
    end

    // Request latch, wait counter, read-data capture and worst-wait statistic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            wait_q  <= '0;
            stat_q  <= '0;
            cpu_q_q <= '0;
        end else begin
            if (state_q == IDLE && bus.cpu_start) begin
                a_q    <= bus.cpu_addr;
                dat_q  <= bus.cpu_data;
                we_q   <= bus.cpu_we;
                wait_q <= '0;
            end else if (state_q == PEND && bus.gpu_req && wait_q != 16'hFFFF) begin
                wait_q <= wait_q + 16'd1;
            end

            // An issuing access overrides a simultaneous clear.
            if (issue) begin
                if (bus.stat_clear || wait_q > stat_q) stat_q <= wait_q;
            end else if (bus.stat_clear) begin
                stat_q <= '0;
            end

            // Synchronous VRAM: data for the issued address arrives in RDWAIT.
            if (state_q == RDWAIT) cpu_q_q <= bus.ram_q;
        end
    end
endmodule

// File: tb/tb_vram_port_arbiter.sv
module tb_vram_port_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    vram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    vram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Initial VRAM contents as a pure function of the address.
    function automatic logic [31:0] seed_val(input logic [13:0] a);
        if (a == 14'h3FFF) return 32'hCAFE0001;
        return ({18'd0, a} * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // VRAM block model: synchronous read, one cycle after the address.
    logic [31:0] mem [0:16383];
    bit          wr  [0:16383];
    always @(posedge clk) begin
        if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_d;
            wr[bus.ram_addr]  <= 1'b1;
        end
        bus.ram_q <= wr[bus.ram_addr] ? mem[bus.ram_addr] : seed_val(bus.ram_addr);
    end

    // Reference model: memory contents as seen by the architecture.
    logic [31:0] refm [int];
    function automatic logic [31:0] ref_rd(input logic [13:0] a);
        return refm.exists(int'(a)) ? refm[int'(a)] : seed_val(a);
    endfunction

    typedef struct {int cyc; logic [31:0] data; bit rd; logic [15:0] stat;} cexp_t;
    typedef struct {int cyc; logic [31:0] data;} gexp_t;
    cexp_t cq[$];
    gexp_t gq[$];

    bit          m_pend = 0;
    int          m_s = 0;
    bit          m_we = 0;
    logic [13:0] m_a = '0;
    logic [31:0] m_d = '0;
    int          m_done = -1;
    logic [15:0] m_stat = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", nm, cyc);
    endtask

    // Drive one cycle of inputs and advance the reference model.
    task automatic step(input bit greq, input logic [13:0] gaddr, input bit st,
                        input bit we, input logic [13:0] a, input logic [31:0] d,
                        input bit clr);
        int w;
        cexp_t ce;
        gexp_t ge;
        @(posedge clk); #1;
        cyc++;
        bus.gpu_req = greq; bus.gpu_addr = gaddr;
        bus.cpu_start = st; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_data = d;
        bus.stat_clear = clr;
        // A pending request takes the first renderer-idle cycle after its start.
        if (m_pend && !greq) begin
            w = cyc - m_s - 1;
            if (w > 65535) w = 65535;
            m_pend = 0;
            if (clr || 16'(w) > m_stat) m_stat = 16'(w);
            ce.stat = m_stat;
            ce.rd = !m_we;
            if (m_we) begin
                refm[int'(m_a)] = m_d;
                ce.cyc = cyc + 1; ce.data = '0;
            end else begin
                ce.cyc = cyc + 2; ce.data = ref_rd(m_a);
            end
            m_done = ce.cyc;
            cq.push_back(ce);
        end else if (clr) begin
            m_stat = '0;
        end
        if (st && !m_pend && cyc > m_done) begin
            m_pend = 1; m_s = cyc; m_we = we; m_a = a; m_d = d;
        end
        if (greq) begin
            ge.cyc = cyc + 1; ge.data = ref_rd(gaddr);
            gq.push_back(ge);
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0);
    endtask

    // Monitor: compares DUT outputs against the queued expectations.
    cexp_t me;
    gexp_t mg;
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.gpu_req) check("ram_we_under_gpu", bus.ram_we, 1'b0);
                while (gq.size() > 0 && gq[0].cyc < cyc) void'(gq.pop_front());
                if (gq.size() > 0 && gq[0].cyc == cyc) begin
                    mg = gq.pop_front();
                    check("gpu_q", bus.gpu_q, mg.data);
                end
                if (cq.size() > 0 && cq[0].cyc < cyc) begin
                    void'(cq.pop_front());
                    flag("cpu_done_timeout");
                end
                if (bus.cpu_done) begin
                    if (cq.size() == 0) flag("cpu_done_unexpected");
                    else begin
                        me = cq.pop_front();
                        check("cpu_done_cycle", cyc, me.cyc);
                        if (me.rd) check("cpu_q", bus.cpu_q, me.data);
                        check("stat_wait_max", bus.stat_wait_max, {16'd0, me.stat});
                    end
                end
            end
        end
    end

    logic [13:0] ga;

    initial begin
        bus.gpu_req = 0; bus.gpu_addr = 14'h0155; bus.cpu_start = 0; bus.cpu_we = 0;
        bus.cpu_addr = '0; bus.cpu_data = '0; bus.stat_clear = 0;
        #2;
        check("rst_busy", bus.cpu_busy, 1'b0);
        check("rst_done", bus.cpu_done, 1'b0);
        check("rst_cpu_q", bus.cpu_q, 32'h0);
        check("rst_stat", bus.stat_wait_max, 32'h0);
        check("rst_ram_we", bus.ram_we, 1'b0);
        check("rst_ram_d", bus.ram_d, 32'h0);
        check("rst_ram_addr", bus.ram_addr, 14'h0155);
        #20 reset_n = 1'b1;

        // Idle write.
        step(1'b0, 14'h0, 1'b1, 1'b1, 14'h0123, 32'hDEADBEEF, 1'b0);
        idle(1);
        check("wr_ram_we", bus.ram_we, 1'b1);
        check("wr_ram_addr", bus.ram_addr, 14'h0123);
        check("wr_ram_d", bus.ram_d, 32'hDEADBEEF);
        check("wr_busy", bus.cpu_busy, 1'b1);
        idle(1);
        check("wr_done", bus.cpu_done, 1'b1);
        check("wr_stat", bus.stat_wait_max, 32'h0);

        // Read blocked by five renderer cycles.
        step(1'b0, 14'h0, 1'b1, 1'b0, 14'h3FFF, 32'h0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            ga = 14'($urandom);
            step(1'b1, ga, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0);
            check("blk_ram_addr", bus.ram_addr, ga);
            check("blk_ram_we", bus.ram_we, 1'b0);
        end
        idle(1);
        check("blk_issue_addr", bus.ram_addr, 14'h3FFF);
        idle(2);
        check("blk_done", bus.cpu_done, 1'b1);
        check("blk_cpu_q", bus.cpu_q, 32'hCAFE0001);
        check("blk_stat", bus.stat_wait_max, 32'd5);

        // Starts in PEND and RDWAIT are ignored.
        step(1'b0, 14'h0, 1'b1, 1'b0, 14'h0010, 32'h0, 1'b0);
        step(1'b1, 14'h0007, 1'b1, 1'b1, 14'h0020, 32'h12345678, 1'b0);
        step(1'b1, 14'h0008, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0);
        idle(1);
        check("ign_issue_addr", bus.ram_addr, 14'h0010);
        check("ign_issue_we", bus.ram_we, 1'b0);
        step(1'b1, 14'h0009, 1'b1, 1'b1, 14'h0030, 32'h87654321, 1'b0);
        idle(1);
        check("ign_done", bus.cpu_done, 1'b1);
        idle(3);
        check("ign_no_write20", wr[14'h0020], 1'b0);
        check("ign_no_write30", wr[14'h0030], 1'b0);

        // Reset in the middle of a blocked write.
        step(1'b0, 14'h0, 1'b1, 1'b1, 14'h0040, 32'h11112222, 1'b0);
        step(1'b1, 14'h0155, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0);
        #2 reset_n = 1'b0;
        m_pend = 0; m_stat = '0; m_done = -1; cq.delete();
        #1;
        check("arst_busy", bus.cpu_busy, 1'b0);
        check("arst_ram_we", bus.ram_we, 1'b0);
        check("arst_ram_d", bus.ram_d, 32'h0);
        check("arst_ram_addr", bus.ram_addr, 14'h0155);
        check("arst_stat", bus.stat_wait_max, 32'h0);
        check("arst_cpu_q", bus.cpu_q, 32'h0);
        #10 reset_n = 1'b1;
        idle(6);
        check("arst_no_write", wr[14'h0040], 1'b0);

        // Randomized renderer traffic interleaved with CPU accesses.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 10) < 6, 14'($urandom % 64), ($urandom % 4) == 0,
                 1'($urandom), 14'($urandom % 64), $urandom, 1'b0);
        end
        idle(4);

        // Wait counter saturation.
        step(1'b0, 14'h0, 1'b1, 1'b0, 14'h0005, 32'h0, 1'b0);
        for (int i = 0; i < 65600; i++) step(1'b1, 14'($urandom), 1'b0, 1'b0, 14'h0, 32'h0, 1'b0);
        idle(2);
        check("sat_stat", bus.stat_wait_max, 32'h0000FFFF);
        idle(2);
        // Clear on its own.
        step(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b1);
        idle(1);
        check("clr_stat", bus.stat_wait_max, 32'h0);
        // Clear coinciding with an issue after three blocked cycles.
        step(1'b0, 14'h0, 1'b1, 1'b1, 14'h0011, 32'hA5A5A5A5, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 14'h0002, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0);
        step(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b1);
        idle(1);
        check("clr_issue_stat", bus.stat_wait_max, 32'd3);
        idle(4);

        if (cq.size() != 0) flag("cpu_done_outstanding");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
